// File: rtl/l1_mem_arbiter_if.sv
// l1_mem_arbiter_if: L1 I/D-cache line request ports and the shared memory refill port
interface l1_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              i_req_read;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_done;
  logic [LINE_W-1:0] i_read_data;
  logic              d_req_read;
  logic              d_req_write;
  logic [ADDR_W-1:0] d_req_addr;
  logic [LINE_W-1:0] d_write_data;
  logic              d_done;
  logic [LINE_W-1:0] d_read_data;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_write_data;
  logic              m_done;
  logic [LINE_W-1:0] m_read_data;
  logic              arb_busy;
  modport master (
    output i_req_read, i_req_addr, d_req_read, d_req_write, d_req_addr, d_write_data, m_done, m_read_data,
    input  i_done, i_read_data, d_done, d_read_data, m_read, m_write, m_addr, m_write_data, arb_busy
  );
  modport slave (
    input  i_req_read, i_req_addr, d_req_read, d_req_write, d_req_addr, d_write_data, m_done, m_read_data,
    output i_done, i_read_data, d_done, d_read_data, m_read, m_write, m_addr, m_write_data, arb_busy
  );
endinterface

// File: rtl/l1_mem_arbiter.sv
// l1_mem_arbiter: serialises L1 I-cache refills and D-cache refills/write-backs onto one line port
// Define ARB_RR_EN for round-robin arbitration; default is D priority with an I starvation guard.
module l1_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 256,
  parameter int STARVE_LIMIT = 4
) (
  input logic sys_clk,
  input logic rst_n,
  l1_mem_arbiter_if.slave bus
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
  state_t state;
  logic d_any, gnt_i, gnt_d, d_wr;
`ifdef ARB_RR_EN
  logic last_i;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_cnt;
`endif
  always_comb begin
    d_any = bus.d_req_read | bus.d_req_write;
    d_wr  = bus.d_req_write;
`ifdef ARB_RR_EN
    gnt_i = state == IDLE && bus.i_req_read && (!d_any || !last_i);
`else
    gnt_i = state == IDLE && bus.i_req_read && (!d_any || starve_cnt == CW'(STARVE_LIMIT));
`endif
    gnt_d = state == IDLE && d_any && !gnt_i;
  end
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      bus.i_done       <= 1'b0;
      bus.d_done       <= 1'b0;
      bus.m_read       <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_addr       <= '0;
      bus.m_write_data <= '0;
      bus.i_read_data  <= '0;
      bus.d_read_data  <= '0;
      bus.arb_busy     <= 1'b0;
`ifdef ARB_RR_EN
      last_i           <= 1'b0;
`else
      starve_cnt       <= '0;
`endif
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      case (state)
        IDLE: if (gnt_i || gnt_d) begin
          state            <= gnt_i ? GNT_I : GNT_D;
          bus.m_read       <= gnt_i || !d_wr;
          bus.m_write      <= gnt_d && d_wr;
          bus.m_addr       <= (gnt_i ? bus.i_req_addr : bus.d_req_addr) & LINE_MASK;
          bus.m_write_data <= (gnt_d && d_wr) ? bus.d_write_data : '0;
          bus.arb_busy     <= 1'b1;
        end
        GNT_I, GNT_D: if (bus.m_done) begin
          state       <= RESP;
          bus.m_read  <= 1'b0;
          bus.m_write <= 1'b0;
          if (state == GNT_I) begin
            bus.i_read_data <= bus.m_read_data;
            bus.i_done      <= 1'b1;
          end else begin
            if (bus.m_read) bus.d_read_data <= bus.m_read_data;
            bus.d_done <= 1'b1;
          end
        end
        RESP: begin
          state        <= IDLE;
          bus.arb_busy <= 1'b0;
        end
      endcase
`ifdef ARB_RR_EN
      if (gnt_i || gnt_d) last_i <= gnt_i;
`else
      // consecutive D wins only count while I is actually waiting
      starve_cnt <= (!bus.i_req_read || gnt_i) ? '0 : gnt_d ? starve_cnt + 1'b1 : starve_cnt;
`endif
    end
  end
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb_l1_mem_arbiter: scoreboard bench; expected memory transactions and requester responses are
// queued by the stimulus and popped by monitors whenever the DUT starts a transaction or pulses done.
module tb_l1_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;
  l1_mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();
  l1_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(4)) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {logic wr; logic [AW-1:0] addr; logic [LW-1:0] wdata;} mexp_t;
  typedef struct {logic is_i; logic [LW-1:0] data;} rexp_t;
  mexp_t mq[$];
  rexp_t rq[$];
  mexp_t me;
  rexp_t re;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int mdone_cyc = -10;
  int mem_lat = 5;
  int mcnt = 0;
  int d_more = 0;
  logic act, act_prev = 1'b0;
  logic [AW-1:0] cur_addr;
  logic [LW-1:0] cur_wd;
  logic cur_wr;
  logic [LW-1:0] exp_d_rd = '0;
  localparam logic [LW-1:0] W1 = {8{32'hC0DE_0001}};
  localparam logic [LW-1:0] W2 = {8{32'hBEEF_0002}};
  localparam logic [LW-1:0] W3 = {8{32'h1357_0003}};
  function automatic logic [LW-1:0] mem_line(logic [AW-1:0] a);
    return {8{a ^ 32'h5A5A_0F0F}};
  endfunction
  function automatic void chk(string name, logic [LW-1:0] act_v, logic [LW-1:0] exp_v);
    tests++;
    if (act_v !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
    end
  endfunction
  function automatic void push_m(logic wr, logic [AW-1:0] addr, logic [LW-1:0] wd);
    mexp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wd;
    mq.push_back(e);
  endfunction
  function automatic void push_r(logic is_i, logic [LW-1:0] data);
    rexp_t e;
    e.is_i = is_i; e.data = data;
    rq.push_back(e);
  endfunction
  // memory model: completes each transaction mem_lat cycles after it is presented
  always @(negedge sys_clk) begin
    bus.m_done = 1'b0;
    if (!rst_n || !(bus.m_read || bus.m_write)) mcnt = 0;
    else begin
      mcnt++;
      if (mcnt == mem_lat) begin
        bus.m_done = 1'b1;
        bus.m_read_data = mem_line(bus.m_addr);
        mdone_cyc = cyc;
      end
    end
  end
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    act = bus.m_read || bus.m_write;
    if (rst_n) begin
      if (act && !act_prev) begin
        if (mq.size() == 0) chk("unexpected_mem_txn", 1'b1, 1'b0);
        else begin
          me = mq.pop_front();
          chk("m_write", bus.m_write, me.wr);
          chk("m_read", bus.m_read, !me.wr);
          chk("m_addr", bus.m_addr, me.addr);
          if (me.wr) chk("m_write_data", bus.m_write_data, me.wdata);
          cur_addr = bus.m_addr; cur_wd = bus.m_write_data; cur_wr = bus.m_write;
        end
      end else if (act) begin
        chk("m_addr_stable", bus.m_addr, cur_addr);
        chk("m_wdata_stable", bus.m_write_data, cur_wd);
        chk("m_write_stable", bus.m_write, cur_wr);
      end
      if (bus.i_done || bus.d_done) begin
        chk("done_latency", cyc, mdone_cyc + 1);
        chk("single_done", bus.i_done && bus.d_done, 1'b0);
        if (rq.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
        else begin
          re = rq.pop_front();
          chk("done_requester_is_i", bus.i_done, re.is_i);
          chk(re.is_i ? "i_read_data" : "d_read_data", re.is_i ? bus.i_read_data : bus.d_read_data, re.data);
        end
      end
    end
    act_prev = rst_n && act;
  end
  task automatic drain(input int budget);
    int n = 0;
    while ((bus.i_req_read || bus.d_req_read || bus.d_req_write || bus.arb_busy) && n < budget) begin
      @(negedge sys_clk);
      n++;
      if (bus.i_done) bus.i_req_read = 1'b0;
      if (bus.d_done) begin
        if (d_more > 0) d_more--;
        else begin bus.d_req_read = 1'b0; bus.d_req_write = 1'b0; end
      end
    end
    chk("drain_timeout", n >= budget, 1'b0);
  endtask
  task automatic wait_done(input bit is_i, input int budget);
    int n = 0;
    while (!(is_i ? bus.i_done : bus.d_done) && n < budget) begin @(negedge sys_clk); n++; end
    chk(is_i ? "wait_i_done_timeout" : "wait_d_done_timeout", n >= budget, 1'b0);
    if (is_i) bus.i_req_read = 1'b0;
    else begin bus.d_req_read = 1'b0; bus.d_req_write = 1'b0; end
  endtask
  task automatic wait_mwrite(input int budget);
    int n = 0;
    while (!bus.m_write && n < budget) begin @(negedge sys_clk); n++; end
    chk("wait_m_write_timeout", n >= budget, 1'b0);
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_i_done"}, bus.i_done, 1'b0);
    chk({tag, "_d_done"}, bus.d_done, 1'b0);
    chk({tag, "_m_read"}, bus.m_read, 1'b0);
    chk({tag, "_m_write"}, bus.m_write, 1'b0);
    chk({tag, "_m_addr"}, bus.m_addr, '0);
    chk({tag, "_m_write_data"}, bus.m_write_data, '0);
    chk({tag, "_i_read_data"}, bus.i_read_data, '0);
    chk({tag, "_d_read_data"}, bus.d_read_data, '0);
    chk({tag, "_arb_busy"}, bus.arb_busy, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.i_req_read = 0; bus.i_req_addr = '0;
    bus.d_req_read = 0; bus.d_req_write = 0; bus.d_req_addr = '0; bus.d_write_data = '0;
    bus.m_done = 0; bus.m_read_data = '0;
    repeat (3) @(negedge sys_clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge sys_clk);
    // I read alone, unaligned address
    mem_lat = 5;
    push_m(1'b0, 32'h0000_1220, '0);
    push_r(1'b1, mem_line(32'h0000_1220));
    bus.i_req_read = 1; bus.i_req_addr = 32'h0000_1234;
    @(posedge sys_clk); #2;
    chk("turnaround_m_read", bus.m_read, 1'b1);
    drain(100);
    // D write-back
    push_m(1'b1, 32'h8000_0040, W1);
    push_r(1'b0, exp_d_rd);
    bus.d_req_write = 1; bus.d_req_addr = 32'h8000_0040; bus.d_write_data = W1;
    drain(100);
    // simultaneous I and D requests, last grant was D
    mem_lat = 3;
    bus.i_req_read = 1; bus.i_req_addr = 32'h0000_2040;
    bus.d_req_read = 1; bus.d_req_addr = 32'h0000_7080;
`ifdef ARB_RR_EN
    push_m(1'b0, 32'h0000_2040, '0); push_r(1'b1, mem_line(32'h0000_2040));
    push_m(1'b0, 32'h0000_7080, '0); exp_d_rd = mem_line(32'h0000_7080); push_r(1'b0, exp_d_rd);
    wait_done(1'b1, 100);
`else
    push_m(1'b0, 32'h0000_7080, '0); exp_d_rd = mem_line(32'h0000_7080); push_r(1'b0, exp_d_rd);
    push_m(1'b0, 32'h0000_2040, '0); push_r(1'b1, mem_line(32'h0000_2040));
    wait_done(1'b0, 100);
`endif
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("second_grant_right_after_resp", bus.m_read, 1'b1);
    drain(100);
`ifndef ARB_RR_EN
    // I held while D keeps re-requesting: four D grants, then I, then D again
    mem_lat = 2;
    exp_d_rd = mem_line(32'h0000_4000);
    for (int k = 0; k < 4; k++) begin push_m(1'b0, 32'h0000_4000, '0); push_r(1'b0, exp_d_rd); end
    push_m(1'b0, 32'h0000_2000, '0); push_r(1'b1, mem_line(32'h0000_2000));
    push_m(1'b0, 32'h0000_4000, '0); push_r(1'b0, exp_d_rd);
    d_more = 4;
    bus.i_req_read = 1; bus.i_req_addr = 32'h0000_2000;
    bus.d_req_read = 1; bus.d_req_addr = 32'h0000_4000;
    drain(300);
`endif
    // D inputs change while granted; memory side must keep latched values
    mem_lat = 6;
    push_m(1'b1, 32'h0000_3000, W2);
    push_r(1'b0, exp_d_rd);
    bus.d_req_write = 1; bus.d_req_addr = 32'h0000_3010; bus.d_write_data = W2;
    wait_mwrite(50);
    bus.d_req_addr = 32'hFFFF_FFC0; bus.d_write_data = ~W2;
    drain(100);
    // reset during a D write abandons it
    mem_lat = 20;
    push_m(1'b1, 32'h0000_5000, W3);
    bus.d_req_write = 1; bus.d_req_addr = 32'h0000_5000; bus.d_write_data = W3;
    wait_mwrite(50);
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b0; bus.d_req_write = 0;
    @(posedge sys_clk); #2;
    chk_zero_outputs("midreset");
    @(negedge sys_clk);
    rst_n = 1'b1;
    exp_d_rd = '0;
    mem_lat = 3;
    push_m(1'b0, 32'h0000_6000, '0);
    push_r(1'b1, mem_line(32'h0000_6000));
    bus.i_req_read = 1; bus.i_req_addr = 32'h0000_6004;
    drain(100);
    repeat (3) @(negedge sys_clk);
    chk("mem_queue_empty", mq.size(), 0);
    chk("resp_queue_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
